// File: rtl/score_pkg.sv
// Shared types and constants for the score controller and its scoreboard interface.
// Scores are 2-bit saturating counters; player encoding matches the turn output.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    RESOLVE,
    GAME_OVER
  } state_t;

  localparam int SCORE_W = 2;
  localparam logic [SCORE_W-1:0] MAX_SCORE = 2'd3;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == MAX_SCORE) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Terminal-count counter: done pulses combinationally in the cycle the count sits at LIMIT-1 while enabled.
// clr dominates en and suppresses done; the count wraps to zero after done.
module cycle_timer #(
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  assign done = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || done) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/score_controller.sv
// Game sequencer: accepts one shot per two cycles (ready drops for the RESOLVE cycle), updates scores,
// alternates turns, passes the turn on inactivity and blinks the display once a winner is found.
module score_controller
  import score_pkg::*;
#(
  parameter int WIN_SCORE    = 3,
  parameter int TURN_TIMEOUT = 500000000,
  parameter int BLINK_DIV    = 50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               shot_valid,
  input  logic               shot_hit,
  output logic               shot_ready,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               turn,
  output logic               game_over,
  output logic               winner,
  output logic               blink
);

  localparam logic [SCORE_W-1:0] WIN_LVL = SCORE_W'(WIN_SCORE);

  state_t             state, state_nx;
  logic [SCORE_W-1:0] p1_nx, p2_nx, cur_score;
  logic               turn_nx, game_over_nx, winner_nx, blink_nx;
  logic               accept, tmo_clr, tmo_done, blink_clr, blink_done;

  // start outranks a simultaneous shot, so the shot is simply never accepted
  assign accept    = shot_valid && shot_ready && !start;
  assign cur_score = (turn == PLAYER2) ? p2_score : p1_score;
  assign tmo_clr   = start || accept || (state != TURN);
  assign blink_clr = start || (state != GAME_OVER);

  cycle_timer #(.LIMIT(TURN_TIMEOUT)) u_turn_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmo_clr),
    .en    (state == TURN),
    .done  (tmo_done)
  );

  cycle_timer #(.LIMIT(BLINK_DIV)) u_blink_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (blink_clr),
    .en    (state == GAME_OVER),
    .done  (blink_done)
  );

  always_comb begin
    state_nx     = state;
    p1_nx        = p1_score;
    p2_nx        = p2_score;
    turn_nx      = turn;
    game_over_nx = game_over;
    winner_nx    = winner;
    blink_nx     = blink;
    if (start) begin
      state_nx     = TURN;
      p1_nx        = '0;
      p2_nx        = '0;
      turn_nx      = PLAYER1;
      game_over_nx = 1'b0;
      winner_nx    = PLAYER1;
      blink_nx     = 1'b0;
    end else begin
      case (state)
        TURN: begin
          if (accept) begin
            state_nx = RESOLVE;
            if (shot_hit) begin
              if (turn == PLAYER1) p1_nx = sat_inc(p1_score);
              else                 p2_nx = sat_inc(p2_score);
            end
          end else if (tmo_done) begin
            turn_nx = ~turn;
          end
        end
        RESOLVE: begin
          if (cur_score >= WIN_LVL) begin
            state_nx     = GAME_OVER;
            game_over_nx = 1'b1;
            winner_nx    = turn;
          end else begin
            state_nx = TURN;
            turn_nx  = ~turn;
          end
        end
        GAME_OVER: begin
          if (blink_done) blink_nx = ~blink;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      p1_score   <= '0;
      p2_score   <= '0;
      turn       <= PLAYER1;
      game_over  <= 1'b0;
      winner     <= PLAYER1;
      blink      <= 1'b0;
      shot_ready <= 1'b0;
    end else begin
      state      <= state_nx;
      p1_score   <= p1_nx;
      p2_score   <= p2_nx;
      turn       <= turn_nx;
      game_over  <= game_over_nx;
      winner     <= winner_nx;
      blink      <= blink_nx;
      shot_ready <= (state_nx == TURN);
    end
  end

endmodule

// File: tb/tb_score_controller.sv
// Bench for score_controller: directed scenarios with literal checks plus random play,
// all outputs compared every cycle against a rule-level game model.
module tb_score_controller;

  localparam int WIN = 3;
  localparam int TT  = 8;
  localparam int BD  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, shot_valid, shot_hit;
  logic       shot_ready, turn, game_over, winner, blink;
  logic [1:0] p1_score, p2_score;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  score_controller #(.WIN_SCORE(WIN), .TURN_TIMEOUT(TT), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .shot_valid (shot_valid),
    .shot_hit   (shot_hit),
    .shot_ready (shot_ready),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .turn       (turn),
    .game_over  (game_over),
    .winner     (winner),
    .blink      (blink)
  );

  always #5 clk = ~clk;

  // Game model: phase 0 idle, 1 waiting for a shot, 2 judging a shot, 3 finished.
  int m_phase = 0;
  int m_sc[2] = '{0, 0};
  int m_turn = 0, m_wait = 0, m_winner = 0, m_over_cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_sc[0] = 0; m_sc[1] = 0;
      m_turn = 0; m_wait = 0; m_winner = 0; m_over_cyc = 0;
    end else if (start) begin
      m_phase = 1; m_sc[0] = 0; m_sc[1] = 0;
      m_turn = 0; m_wait = 0; m_winner = 0; m_over_cyc = 0;
    end else begin
      case (m_phase)
        1: begin
          if (shot_valid) begin
            if (shot_hit && m_sc[m_turn] < 3) m_sc[m_turn] = m_sc[m_turn] + 1;
            m_phase = 2;
            m_wait  = 0;
          end else begin
            m_wait = m_wait + 1;
            if (m_wait == TT) begin
              m_turn = 1 - m_turn;
              m_wait = 0;
            end
          end
        end
        2: begin
          if (m_sc[m_turn] >= WIN) begin
            m_phase    = 3;
            m_winner   = m_turn;
            m_over_cyc = 0;
          end else begin
            m_turn  = 1 - m_turn;
            m_phase = 1;
            m_wait  = 0;
          end
        end
        3: m_over_cyc = m_over_cyc + 1;
        default: ;
      endcase
    end
  end

  function automatic logic [8:0] model_vec();
    logic [8:0] v;
    v[8]   = (m_phase == 1);
    v[7:6] = 2'(m_sc[0]);
    v[5:4] = 2'(m_sc[1]);
    v[3]   = m_turn[0];
    v[2]   = (m_phase == 3);
    v[1]   = m_winner[0];
    v[0]   = (m_phase == 3) ? ((m_over_cyc / BD) % 2 == 1) : 1'b0;
    return v;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [8:0] act, exp;
      act = {shot_ready, p1_score, p2_score, turn, game_over, winner, blink};
      exp = model_vec();
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got rdy,p1,p2,turn,go,win,blink=%b want=%b", $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shoot(input logic hit);
    shot_valid = 1'b1;
    shot_hit   = hit;
    tick();
    shot_valid = 1'b0;
    tick();
  endtask

  task automatic pulse_start(input logic with_shot);
    start      = 1'b1;
    shot_valid = with_shot;
    shot_hit   = 1'b1;
    tick();
    start      = 1'b0;
    shot_valid = 1'b0;
  endtask

  initial begin
    int quiet;
    rst_n = 1'b1; start = 1'b0; shot_valid = 1'b0; shot_hit = 1'b0;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;

    // 1: reset values, then start
    tick(); tick();
    chk("rst_ready", 4'(shot_ready), 4'd0);
    chk("rst_scores", {p1_score, p2_score}, 4'd0);
    chk("rst_flags", {turn, game_over, winner, blink}, 4'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 4'(shot_ready), 4'd0);
    pulse_start(1'b0);
    chk("start_ready", 4'(shot_ready), 4'd1);
    chk("start_turn", 4'(turn), 4'd0);

    // 2: P1 hit then P2 miss
    shot_valid = 1'b1; shot_hit = 1'b1;
    tick();
    shot_valid = 1'b0;
    chk("hit_p1_n1", 4'(p1_score), 4'd1);
    chk("hit_ready_n1", 4'(shot_ready), 4'd0);
    tick();
    chk("hit_turn_n2", 4'(turn), 4'd1);
    chk("hit_ready_n2", 4'(shot_ready), 4'd1);
    shoot(1'b0);
    chk("miss_scores", {p1_score, p2_score}, 4'b0100);
    chk("miss_turn", 4'(turn), 4'd0);

    // 3: inactivity timeout, then accept on the terminal cycle
    repeat (TT - 1) tick();
    chk("tmo_before", 4'(turn), 4'd0);
    tick();
    chk("tmo_toggle", 4'(turn), 4'd1);
    chk("tmo_scores", {p1_score, p2_score}, 4'b0100);
    repeat (TT - 1) tick();
    shot_valid = 1'b1; shot_hit = 1'b0;
    tick();
    shot_valid = 1'b0;
    chk("tmo_accept_ready", 4'(shot_ready), 4'd0);
    chk("tmo_accept_turn", 4'(turn), 4'd1);
    tick();
    chk("tmo_resolve_turn", 4'(turn), 4'd0);

    // 4: P1 reaches 3
    shoot(1'b1);
    shoot(1'b0);
    shoot(1'b1);
    chk("win_over", {game_over, winner}, 4'b0010);
    chk("win_p1", 4'(p1_score), 4'd3);
    shot_valid = 1'b1; shot_hit = 1'b1;
    repeat (BD - 1) tick();
    chk("blink_low", 4'(blink), 4'd0);
    tick();
    chk("blink_high", 4'(blink), 4'd1);
    repeat (BD) tick();
    chk("blink_low2", 4'(blink), 4'd0);
    chk("over_scores", {p1_score, p2_score}, 4'b1100);
    shot_valid = 1'b0;

    // 5: restart from GAME_OVER and mid-TURN, shot in the start cycle dropped
    pulse_start(1'b1);
    chk("rs1_scores", {p1_score, p2_score}, 4'd0);
    chk("rs1_flags", {turn, game_over, blink, shot_ready}, 4'b0001);
    shoot(1'b1); shoot(1'b1); shoot(1'b1);
    chk("mid_scores", {p1_score, p2_score}, 4'b1001);
    pulse_start(1'b1);
    chk("rs2_scores", {p1_score, p2_score}, 4'd0);
    chk("rs2_flags", {turn, game_over, blink, shot_ready}, 4'b0001);
    tick();
    chk("rs2_nocount", {p1_score, p2_score}, 4'd0);

    // 6: async reset mid-RESOLVE
    shot_valid = 1'b1; shot_hit = 1'b1;
    tick();
    shot_valid = 1'b0;
    chk("pre_rst_p1", 4'(p1_score), 4'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_scores", {p1_score, p2_score}, 4'd0);
    chk("arst_flags", {turn, game_over, winner, blink}, 4'd0);
    chk("arst_ready", 4'(shot_ready), 4'd0);
    tick(); tick();
    rst_n = 1'b1;
    shot_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_idle", 4'(shot_ready), 4'd0);
    end
    shot_valid = 1'b0;
    pulse_start(1'b0);
    chk("post_rst_start", 4'(shot_ready), 4'd1);

    // random play
    quiet = 0;
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 59) == 0);
      if (quiet > 0) begin
        quiet--;
        shot_valid = 1'b0;
      end else begin
        if ($urandom_range(0, 39) == 0) quiet = $urandom_range(5, 20);
        shot_valid = ($urandom_range(0, 2) != 0);
      end
      shot_hit = $urandom_range(0, 1) == 1;
      tick();
    end
    start = 1'b0; shot_valid = 1'b0;
    tick(); tick();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
